md_step_scheduler: RTL and testbench
====================================

# md_step_scheduler

Sequences one timestep loop of the MD engine and arbitrates ownership of the per-cell position/velocity BRAM ports between the particle loader, phase 1 (force/velocity update) and phase 3 (position update/migration). It counts initial particle writes, holds phase 1 ownership through a fixed pipeline-drain window after phase 1 reports done, hands the memories to phase 3, flips the double-buffer select per step, and stops after a programmed number of steps. It sits between the host-side loader and the phase_1/phase_3 blocks and drives the BRAM port-select muxes.

## Interface
- N_PARTICLES, 300, particle writes expected before the run may start
- P1_DRAIN, 99, cycles phase 1 keeps memory ownership after p1_done
- CNT_W, 10, width of load_count
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- load_valid  in  1  loader presents one particle write this cycle
- load_accept  out  1  comb.: load_valid && state==LOAD; loader/BRAM write enable qualifier
- reload  in  1  in IDLE: clear load_count, return to LOAD
- start  in  1  in IDLE: begin a run of n_steps steps
- n_steps  in  32  step count, sampled on accepted start
- p1_done  in  1  phase 1 finished issuing work (level)
- p3_done  in  1  phase 3 finished (level, AND of all cells)
- p1_ready  out  1  phase 1 enabled and owns BRAM ports
- p3_ready  out  1  phase 3 enabled and owns BRAM ports
- mem_sel  out  2  0 LOAD, 1 P1, 2 P3, 3 NONE (all writes blocked)
- double_buffer  out  1  buffer half select, toggles per completed step
- step_count  out  32  completed steps in current run
- load_count  out  CNT_W  accepted particle writes
- busy  out  1  state in P1_RUN..GAP
- done  out  1  one-cycle pulse at run end

## Operation
- States: LOAD, IDLE, P1_RUN, P1_DRAIN, P3_RUN, GAP.
- LOAD: mem_sel=0. Each accepted write increments load_count. When load_count==N_PARTICLES-1 and load_accept, next state IDLE. Writes beyond N_PARTICLES impossible (load_accept low outside LOAD).
- IDLE: mem_sel=3. reload has priority over start -> LOAD, load_count<=0. start with n_steps==0 -> done pulse, stay IDLE. start with n_steps>0 -> latch n_steps, step_count<=0, -> P1_RUN.
- P1_RUN: mem_sel=1, p1_ready=1. p1_done high -> P1_DRAIN, drain counter<=0.
- P1_DRAIN: mem_sel=1, p1_ready=1 (in-flight writebacks). Counter increments; at counter==P1_DRAIN-1 -> P3_RUN.
- P3_RUN: mem_sel=2, p3_ready=1. p3_done high -> step_count+1, double_buffer toggles; if step_count+1==latched n_steps -> done pulse, IDLE; else -> GAP.
- GAP: one cycle, mem_sel=3, both ready low (phase blocks re-arm), -> P1_RUN.
- p1_done outside P1_RUN, p3_done outside P3_RUN, start/reload outside IDLE: ignored.
- step_count and double_buffer hold their values in IDLE until next start; double_buffer not reset by start.
- step_count increment wraps mod 2^32 (unreachable in practice; no saturation).

## Timing
- Reset values: state LOAD, mem_sel 0, p1_ready 0, p3_ready 0, double_buffer 0, step_count 0, load_count 0, busy 0, done 0; drain counter 0.
- All outputs registered except load_accept.
- start at edge k -> p1_ready=1 from cycle k+1.
- p1_done sampled at edge k -> p1_ready stays 1 through k+P1_DRAIN; p3_ready=1 at k+P1_DRAIN+1, never overlapping p1_ready.
- p3_done at edge k -> p3_ready 0, double_buffer toggled, step_count updated at k+1; p1_ready again at k+2 (GAP).
- done asserted exactly one cycle, same cycle as state enters IDLE.
- Reset mid-run: next cycle all outputs at reset values, load required again.

## Test plan
- Load: N_PARTICLES=4, load_valid held 6 cycles -> load_accept high 4 cycles, load_count=4, mem_sel 0->3.
- One step: n_steps=1, start; p1_done after 10 cycles -> p1_ready high 10+P1_DRAIN cycles, then p3_ready; p3_done -> done pulse, step_count=1, double_buffer=1.
- Three steps: n_steps=3 -> three P1/P3 rounds, one GAP cycle between, ready signals never both high, double_buffer final 1, step_count=3.
- n_steps=0 with start -> done pulse next cycle, p1_ready never high.
- Spurious inputs: p3_done during P1_RUN and start during P3_RUN -> no state change; reload in IDLE -> load_count=0, mem_sel=0.
- Reset asserted in P1_DRAIN -> next cycle p1_ready=0, mem_sel=0, step_count=0.

Source files
------------

// File: rtl/md_step_scheduler.sv
// md_step_scheduler
//
// Runs the timestep loop of the MD engine. It decides which agent owns the
// per-cell position/velocity BRAM ports: the particle loader, phase 1
// (force/velocity update) or phase 3 (position update/migration).
//
// Behaviour:
//   - Counts the initial particle writes from the loader.
//   - Keeps phase 1 as the BRAM owner for a fixed drain window after p1_done,
//     so that in-flight writebacks can still land.
//   - Passes the BRAM ports to phase 3.
//   - Flips the double-buffer select after each completed step.
//   - Stops after the programmed number of steps.
//
// Parameters:
//   N_PARTICLES  particle writes expected before a run may start
//   P1_DRAIN     cycles phase 1 keeps ownership after p1_done
//   CNT_W        width of load_count
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   load_valid     loader offers one particle write this cycle
//   load_accept    (comb.) write accepted; write-enable qualifier for loader/BRAM
//   reload         in IDLE: clear load_count and return to LOAD
//   start          in IDLE: begin a run of n_steps steps
//   n_steps        step count, sampled on an accepted start
//   p1_done        phase 1 finished issuing work (level)
//   p3_done        phase 3 finished in all cells (level)
//   p1_ready       phase 1 enabled and owns the BRAM ports
//   p3_ready       phase 3 enabled and owns the BRAM ports
//   mem_sel        BRAM port mux: 0 loader, 1 phase 1, 2 phase 3, 3 none
//   double_buffer  buffer-half select, toggles per completed step
//   step_count     steps completed in the current run
//   load_count     particle writes accepted
//   busy           a run is in progress
//   done           one-cycle pulse when the run ends
module md_step_scheduler #(
  parameter int N_PARTICLES = 300,
  parameter int P1_DRAIN    = 99,
  parameter int CNT_W       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_accept,
  input  logic             reload,
  input  logic             start,
  input  logic [31:0]      n_steps,
  input  logic             p1_done,
  input  logic             p3_done,
  output logic             p1_ready,
  output logic             p3_ready,
  output logic [1:0]       mem_sel,
  output logic             double_buffer,
  output logic [31:0]      step_count,
  output logic [CNT_W-1:0] load_count,
  output logic             busy,
  output logic             done
);

  localparam int DRAIN_W = (P1_DRAIN > 1) ? $clog2(P1_DRAIN) : 1;
  localparam logic [CNT_W-1:0]   LOAD_LAST  = CNT_W'(N_PARTICLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(P1_DRAIN - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_P1_RUN,
    S_P1_DRAIN,
    S_P3_RUN,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   load_count_q, load_count_d;
  logic [31:0]        n_steps_q, n_steps_d;
  logic [31:0]        step_count_q, step_count_d;
  logic               double_buffer_q, double_buffer_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               done_q, done_d;
  logic [1:0]         mem_sel_q, mem_sel_d;
  logic               p1_ready_q, p1_ready_d;
  logic               p3_ready_q, p3_ready_d;
  logic               busy_q, busy_d;
  logic [31:0]        step_inc;

  assign load_accept = load_valid && (state_q == S_LOAD);
  assign step_inc    = step_count_q + 32'd1;

  // Next-state logic and datapath updates.
  always_comb begin
    state_d         = state_q;
    load_count_d    = load_count_q;
    n_steps_d       = n_steps_q;
    step_count_d    = step_count_q;
    double_buffer_d = double_buffer_q;
    drain_d         = drain_q;
    done_d          = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (load_accept) begin
          load_count_d = load_count_q + CNT_W'(1);
          if (load_count_q == LOAD_LAST) begin
            state_d = S_IDLE;
          end
        end
      end

      S_IDLE: begin
        if (reload) begin
          // reload takes priority over start
          load_count_d = '0;
          state_d      = S_LOAD;
        end else if (start) begin
          if (n_steps == 32'd0) begin
            done_d = 1'b1;
          end else begin
            n_steps_d    = n_steps;
            step_count_d = '0;
            state_d      = S_P1_RUN;
          end
        end
      end

      S_P1_RUN: begin
        if (p1_done) begin
          drain_d = '0;
          state_d = S_P1_DRAIN;
        end
      end

      S_P1_DRAIN: begin
        drain_d = drain_q + DRAIN_W'(1);
        if (drain_q == DRAIN_LAST) begin
          state_d = S_P3_RUN;
        end
      end

      S_P3_RUN: begin
        if (p3_done) begin
          step_count_d    = step_inc;
          double_buffer_d = ~double_buffer_q;
          if (step_inc == n_steps_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end
      end

      S_GAP: begin
        state_d = S_P1_RUN;
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // The outputs are decoded from the next state. Registering that decode
  // lets the outputs change on the same edge as the state register.
  always_comb begin
    mem_sel_d  = 2'd3;
    p1_ready_d = 1'b0;
    p3_ready_d = 1'b0;
    busy_d     = 1'b0;
    case (state_d)
      S_LOAD:     mem_sel_d = 2'd0;
      S_IDLE:     mem_sel_d = 2'd3;
      S_P1_RUN,
      S_P1_DRAIN: begin
        mem_sel_d  = 2'd1;
        p1_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_P3_RUN: begin
        mem_sel_d  = 2'd2;
        p3_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_GAP:      busy_d = 1'b1;
      default:    mem_sel_d = 2'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_LOAD;
      load_count_q    <= '0;
      n_steps_q       <= '0;
      step_count_q    <= '0;
      double_buffer_q <= 1'b0;
      drain_q         <= '0;
      done_q          <= 1'b0;
      mem_sel_q       <= 2'd0;
      p1_ready_q      <= 1'b0;
      p3_ready_q      <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      load_count_q    <= load_count_d;
      n_steps_q       <= n_steps_d;
      step_count_q    <= step_count_d;
      double_buffer_q <= double_buffer_d;
      drain_q         <= drain_d;
      done_q          <= done_d;
      mem_sel_q       <= mem_sel_d;
      p1_ready_q      <= p1_ready_d;
      p3_ready_q      <= p3_ready_d;
      busy_q          <= busy_d;
    end
  end

  assign p1_ready      = p1_ready_q;
  assign p3_ready      = p3_ready_q;
  assign mem_sel       = mem_sel_q;
  assign double_buffer = double_buffer_q;
  assign step_count    = step_count_q;
  assign load_count    = load_count_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_md_step_scheduler.sv
module tb_md_step_scheduler;

  localparam int NP    = 4;
  localparam int DRAIN = 5;
  localparam int CW    = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic          load_accept;
  logic          reload;
  logic          start;
  logic [31:0]   n_steps;
  logic          p1_done;
  logic          p3_done;
  logic          p1_ready;
  logic          p3_ready;
  logic [1:0]    mem_sel;
  logic          double_buffer;
  logic [31:0]   step_count;
  logic [CW-1:0] load_count;
  logic          busy;
  logic          done;

  int total   = 0;
  int bad     = 0;
  int overlap = 0;
  logic exp_db = 1'b0;

  md_step_scheduler #(.N_PARTICLES(NP), .P1_DRAIN(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_accept(load_accept),
    .reload(reload), .start(start), .n_steps(n_steps), .p1_done(p1_done),
    .p3_done(p3_done), .p1_ready(p1_ready), .p3_ready(p3_ready), .mem_sel(mem_sel),
    .double_buffer(double_buffer), .step_count(step_count), .load_count(load_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // The phase-ready signals must never both be high.
  always @(negedge clk) if (p1_ready && p3_ready) overlap++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold load_valid for six cycles. Only the first NP writes may be accepted.
  task automatic load_all(input string tag);
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1;
      #1;
      check_val($sformatf("%s_acc%0d", tag, i), load_accept, (i < NP) ? 1 : 0);
      check_val($sformatf("%s_sel%0d", tag, i), mem_sel, (i < NP) ? 0 : 3);
      tick;
    end
    load_valid = 1'b0;
    check_val({tag, "_count"}, load_count, NP);
    check_val({tag, "_selend"}, mem_sel, 3);
  endtask

  task automatic start_run(input string tag, input int n);
    n_steps = n;
    start   = 1'b1;
    tick;
    start   = 1'b0;
    check_val({tag, "_p1rdy"}, p1_ready, 1);
    check_val({tag, "_sel1"}, mem_sel, 1);
    check_val({tag, "_busy"}, busy, 1);
    check_val({tag, "_step0"}, step_count, 0);
  endtask

  // The current cycle is the first P1_RUN cycle. Phase 1 runs for p1_len
  // cycles, then the drain window follows, then phase 3 runs for 3 cycles.
  task automatic run_round(input string tag, input int p1_len, input bit spur);
    int n = 0;
    for (int i = 0; i < p1_len; i++) begin
      if (p1_ready) n++;
      p3_done = spur && (i == 0);
      p1_done = (i == p1_len - 1);
      tick;
    end
    p1_done = 1'b0;
    p3_done = 1'b0;
    for (int i = 0; i < 200 && !p3_ready; i++) begin
      if (p1_ready) n++;
      tick;
    end
    check_val({tag, "_p1cyc"}, n, p1_len + DRAIN);
    check_val({tag, "_p3rdy"}, p3_ready, 1);
    check_val({tag, "_sel2"}, mem_sel, 2);
    if (spur) begin
      n_steps = 1;
      start   = 1'b1;
    end
    tick;
    start = 1'b0;
    check_val({tag, "_p3hold"}, p3_ready, 1);
    tick;
    p3_done = 1'b1;
    tick;
    p3_done = 1'b0;
    exp_db  = ~exp_db;
    check_val({tag, "_p3off"}, p3_ready, 0);
    check_val({tag, "_db"}, double_buffer, exp_db);
  endtask

  task automatic gap_check(input string tag, input int steps);
    check_val({tag, "_gapsel"}, mem_sel, 3);
    check_val({tag, "_gapp1"}, p1_ready, 0);
    check_val({tag, "_gapbusy"}, busy, 1);
    check_val({tag, "_gapstep"}, step_count, steps);
    tick;
    check_val({tag, "_rearm"}, p1_ready, 1);
  endtask

  task automatic end_check(input string tag, input int steps);
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_endsel"}, mem_sel, 3);
    check_val({tag, "_endbusy"}, busy, 0);
    check_val({tag, "_steps"}, step_count, steps);
    tick;
    check_val({tag, "_donepulse"}, done, 0);
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; reload = 1'b0; start = 1'b0;
    n_steps = '0; p1_done = 1'b0; p3_done = 1'b0;
    tick; tick;
    reset = 1'b0;
    check_val("rst_sel", mem_sel, 0);
    check_val("rst_p1", p1_ready, 0);
    check_val("rst_p3", p3_ready, 0);
    check_val("rst_db", double_buffer, 0);
    check_val("rst_step", step_count, 0);
    check_val("rst_load", load_count, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);

    load_all("load1");

    // Three steps. The second round injects p3_done during P1_RUN and start during P3_RUN.
    start_run("s3", 3);
    run_round("s3r1", 3, 1'b0);
    gap_check("s3r1", 1);
    run_round("s3r2", 4, 1'b1);
    gap_check("s3r2", 2);
    run_round("s3r3", 2, 1'b0);
    end_check("s3", 3);

    // Zero steps: only a done pulse is produced.
    n_steps = 0;
    start   = 1'b1;
    tick;
    start   = 1'b0;
    check_val("z_done", done, 1);
    check_val("z_p1", p1_ready, 0);
    check_val("z_sel", mem_sel, 3);
    tick;
    check_val("z_donepulse", done, 0);
    check_val("z_p1b", p1_ready, 0);

    // reload has priority over start.
    reload  = 1'b1;
    start   = 1'b1;
    n_steps = 5;
    tick;
    reload  = 1'b0;
    start   = 1'b0;
    check_val("rl_count", load_count, 0);
    check_val("rl_sel", mem_sel, 0);
    check_val("rl_busy", busy, 0);
    load_all("load2");

    // Reset while in P1_DRAIN.
    start_run("rd", 2);
    tick;
    p1_done = 1'b1;
    tick;
    p1_done = 1'b0;
    tick;
    check_val("rd_indrain", p1_ready, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_db = 1'b0;
    check_val("rd_p1", p1_ready, 0);
    check_val("rd_sel", mem_sel, 0);
    check_val("rd_step", step_count, 0);
    check_val("rd_load", load_count, 0);
    check_val("rd_db", double_buffer, 0);
    check_val("rd_busy", busy, 0);

    // One step after reloading.
    load_all("load3");
    start_run("s1", 1);
    run_round("s1r1", 10, 1'b0);
    end_check("s1", 1);
    check_val("s1_db", double_buffer, 1);

    check_val("no_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
